demux_byte_collector: RTL and testbench



---
 rtl/demux_byte_collector_if.sv | 28 ++
 rtl/demux_byte_collector.sv | 121 ++++++++++++
 tb/tb_demux_byte_collector.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/demux_byte_collector_if.sv
// Bus between the 1-to-4 demux side and the byte collector: routed bits in,
// assembled words out on a valid/ready port, plus sticky overflow flags.
interface demux_byte_collector_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [1:0]       sel;
    logic             y0;
    logic             y1;
    logic             y2;
    logic             y3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_ch;
    logic [3:0]       ovf;
    logic             ovf_clr;

    modport master (
        output in_valid, sel, y0, y1, y2, y3, out_ready, ovf_clr,
        input  out_valid, out_data, out_ch, ovf
    );

    modport slave (
        input  in_valid, sel, y0, y1, y2, y3, out_ready, ovf_clr,
        output out_valid, out_data, out_ch, ovf
    );
endinterface

// File: rtl/demux_byte_collector.sv
// Collects demux bits into per-channel MSB-first words, parks one finished word
// per channel and hands them out round-robin on a registered valid/ready port.
module demux_byte_collector #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_byte_collector_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q   [4];
    logic [WIDTH-1:0] sh_d   [4];
    logic [WIDTH-1:0] hold_q [4];
    logic [WIDTH-1:0] hold_d [4];
    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       ovf_q, ovf_d;
    logic [1:0]       last_ch_q, last_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_ch_q, out_ch_d;

    logic [3:0]       y_vec;
    logic             bit_in;
    logic [WIDTH-1:0] word;
    logic             load;
    logic             gnt_v;
    logic [1:0]       gnt_ch;
    logic [1:0]       idx;

    always_comb begin
        y_vec  = {bus.y3, bus.y2, bus.y1, bus.y0};
        bit_in = y_vec[bus.sel];
        word   = {sh_q[bus.sel][WIDTH-2:0], bit_in};
        load   = !out_valid_q || bus.out_ready;

        // Round-robin search starting just after the last channel served.
        gnt_v  = 1'b0;
        gnt_ch = 2'd0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_ch_q + 2'(k);
            if (!gnt_v && pend_q[idx]) begin
                gnt_v  = 1'b1;
                gnt_ch = idx;
            end
        end

        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        ovf_d       = bus.ovf_clr ? 4'b0000 : ovf_q;
        last_ch_d   = last_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;

        if (load) begin
            if (gnt_v) begin
                out_valid_d    = 1'b1;
                out_data_d     = hold_q[gnt_ch];
                out_ch_d       = gnt_ch;
                last_ch_d      = gnt_ch;
                pend_d[gnt_ch] = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        // A completion on a channel whose parked word leaves this edge refills it.
        if (bus.in_valid) begin
            sh_d[bus.sel] = word;
            if (cnt_q[bus.sel] == LAST_BIT) begin
                cnt_d[bus.sel] = '0;
                if (pend_q[bus.sel] && !(load && gnt_v && gnt_ch == bus.sel)) begin
                    ovf_d[bus.sel] = 1'b1;
                end else begin
                    hold_d[bus.sel] = word;
                    pend_d[bus.sel] = 1'b1;
                end
            end else begin
                cnt_d[bus.sel] = cnt_q[bus.sel] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                sh_q[c]   <= '0;
                hold_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            pend_q      <= 4'b0000;
            ovf_q       <= 4'b0000;
            last_ch_q   <= 2'd3;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= 2'd0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            last_ch_q   <= last_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_demux_byte_collector.sv
// Directed bench for demux_byte_collector: word assembly, interleaving,
// round-robin drain after a stall, overflow, same-edge refill and async reset.
module tb_demux_byte_collector;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux_byte_collector_if #(.WIDTH(8)) bus ();

    demux_byte_collector #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unselected y lines get random values; only y[ch] carries the bit.
    task automatic send_bit(input logic [1:0] ch, input logic b);
        logic [3:0] yv;
        yv       = 4'($urandom);
        yv[ch]   = b;
        bus.in_valid = 1'b1;
        bus.sel  = ch;
        bus.y0   = yv[0];
        bus.y1   = yv[1];
        bus.y2   = yv[2];
        bus.y3   = yv[3];
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] ch, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(ch, w[i]);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            check({tag, "_data"}, 32'(bus.out_data), 32'(d));
            check({tag, "_ch"},   32'(bus.out_ch),   32'(c));
        end
    endtask

    initial begin
        logic [7:0] w55;
        logic [7:0] wa, wb;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.sel = 2'd0;
        bus.y0 = 1'b0; bus.y1 = 1'b0; bus.y2 = 1'b0; bus.y3 = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clr = 1'b0;
        #12;
        check_out("rst", 1'b0, 8'h00, 2'd0);
        check("rst_data", 32'(bus.out_data), 32'h0);
        check("rst_ch", 32'(bus.out_ch), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        rst = 1'b0;
        tick();

        // Single word on ch2
        send_word(2'd2, 8'hB2);
        check("t1_pend_only", 32'(bus.out_valid), 32'h0);
        tick();
        check_out("t1_word", 1'b1, 8'hB2, 2'd2);
        check("t1_ovf", 32'(bus.ovf), 32'h0);
        tick();
        check("t1_one_cycle", 32'(bus.out_valid), 32'h0);

        // Interleaved ch0 / ch3
        wa = 8'h5A;
        wb = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            send_bit(2'd0, wa[i]);
            send_bit(2'd3, wb[i]);
        end
        check_out("t2_ch0", 1'b1, 8'h5A, 2'd0);
        tick();
        check_out("t2_ch3", 1'b1, 8'hC3, 2'd3);
        tick();
        check("t2_idle", 32'(bus.out_valid), 32'h0);

        // Stall with ch3 word presented, fill 1,2,3,0, then drain
        bus.out_ready = 1'b0;
        send_word(2'd3, 8'h3F);
        tick();
        check_out("t3_present", 1'b1, 8'h3F, 2'd3);
        send_word(2'd1, 8'hA1);
        check_out("t3_stall1", 1'b1, 8'h3F, 2'd3);
        send_word(2'd2, 8'hA2);
        send_word(2'd3, 8'hA3);
        check_out("t3_stall3", 1'b1, 8'h3F, 2'd3);
        send_word(2'd0, 8'hA0);
        check_out("t3_stall0", 1'b1, 8'h3F, 2'd3);
        check("t3_ovf", 32'(bus.ovf), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check_out("t3_rr0", 1'b1, 8'hA0, 2'd0);
        tick();
        check_out("t3_rr1", 1'b1, 8'hA1, 2'd1);
        tick();
        check_out("t3_rr2", 1'b1, 8'hA2, 2'd2);
        tick();
        check_out("t3_rr3", 1'b1, 8'hA3, 2'd3);
        tick();
        check("t3_idle", 32'(bus.out_valid), 32'h0);

        // Overflow on ch1
        bus.out_ready = 1'b0;
        send_word(2'd1, 8'h11);
        tick();
        send_word(2'd1, 8'h22);
        check("t4_no_ovf_yet", 32'(bus.ovf), 32'h0);
        send_word(2'd1, 8'h33);
        check("t4_ovf", 32'(bus.ovf), 32'h2);
        check_out("t4_held", 1'b1, 8'h11, 2'd1);
        bus.out_ready = 1'b1;
        tick();
        check_out("t4_second", 1'b1, 8'h22, 2'd1);
        tick();
        check("t4_dropped", 32'(bus.out_valid), 32'h0);
        check("t4_sticky", 32'(bus.ovf), 32'h2);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("t4_clr", 32'(bus.ovf), 32'h0);

        // Completion on the edge its pending word moves out
        bus.out_ready = 1'b0;
        send_word(2'd1, 8'h44);
        tick();
        send_word(2'd1, 8'h22);
        w55 = 8'h55;
        for (int i = 7; i >= 1; i--) send_bit(2'd1, w55[i]);
        check_out("t5_stalled", 1'b1, 8'h44, 2'd1);
        bus.out_ready = 1'b1;
        send_bit(2'd1, w55[0]);
        check_out("t5_old", 1'b1, 8'h22, 2'd1);
        check("t5_ovf", 32'(bus.ovf), 32'h0);
        tick();
        check_out("t5_new", 1'b1, 8'h55, 2'd1);
        tick();
        check("t5_idle", 32'(bus.out_valid), 32'h0);

        // Async reset mid-word and mid-handshake
        bus.out_ready = 1'b0;
        send_word(2'd2, 8'h66);
        tick();
        for (int i = 0; i < 5; i++) send_bit(2'd0, 1'b1);
        check_out("t6_before", 1'b1, 8'h66, 2'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t6_rst_data", 32'(bus.out_data), 32'h0);
        check("t6_rst_ch", 32'(bus.out_ch), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        send_word(2'd0, 8'h96);
        check("t6_no_leftover", 32'(bus.out_valid), 32'h0);
        tick();
        check_out("t6_fresh", 1'b1, 8'h96, 2'd0);
        tick();
        check("t6_idle", 32'(bus.out_valid), 32'h0);
        check("t6_ovf", 32'(bus.ovf), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
